vermicel_cpu: RTL and testbench

Non-pipelined, multi-cycle RV32I processor core with separate instruction and data request ports. It fetches, decodes, executes and retires one instruction at a time, so at most one port is active in any cycle. A shared memory or interconnect sits on the other side of both ports; an upper level may merge them into one bus with a simple valid-based mux.

---
 rtl/vermicel_pkg.sv | 87 ++++++++
 rtl/vermicel_regs.sv | 29 ++
 rtl/vermicel_cpu.sv | 190 +++++++++++++++++++
 tb/tb_vermicel_cpu.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vermicel_pkg.sv
// rtl/vermicel_pkg.sv - shared types, RV32I encodings, ALU helper and assembler functions
package vermicel_pkg;

    typedef logic [31:0] word_t;
    typedef logic [3:0]  wstrobe_t;
    typedef logic [4:0]  register_index_t;
    typedef logic [2:0]  state_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_ADD  = 3'd0, F3_SLL = 3'd1, F3_SLT = 3'd2, F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4, F3_SR  = 3'd5, F3_OR  = 3'd6, F3_AND  = 3'd7;
    localparam logic [2:0] F3_BEQ  = 3'd0, F3_BNE = 3'd1, F3_BLT = 3'd4, F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6, F3_BGEU = 3'd7;
    localparam logic [2:0] F3_B    = 3'd0, F3_H   = 3'd1, F3_W   = 3'd2;
    localparam logic [2:0] F3_BU   = 3'd4, F3_HU  = 3'd5;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam state_t ST_FETCH     = 3'd0;
    localparam state_t ST_DECODE    = 3'd1;
    localparam state_t ST_EXECUTE   = 3'd2;
    localparam state_t ST_LOAD      = 3'd3;
    localparam state_t ST_STORE     = 3'd4;
    localparam state_t ST_WRITEBACK = 3'd5;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_fn_t;

    function automatic word_t alu(input alu_fn_t fn, input word_t a, input word_t b);
        case (fn)
            ALU_SUB:  return a - b;
            ALU_SLL:  return a << b[4:0];
            ALU_SLT:  return {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU: return {31'd0, a < b};
            ALU_XOR:  return a ^ b;
            ALU_SRL:  return a >> b[4:0];
            ALU_SRA:  return word_t'($signed(a) >>> b[4:0]);
            ALU_OR:   return a | b;
            ALU_AND:  return a & b;
            default:  return a + b;
        endcase
    endfunction

    function automatic word_t asm_r(input logic [6:0] f7, input logic [2:0] f3,
                                    input register_index_t rd, input register_index_t rs1,
                                    input register_index_t rs2);
        return {f7, rs2, rs1, f3, rd, OPC_OP};
    endfunction

    function automatic word_t asm_i(input logic [6:0] opc, input register_index_t rd,
                                    input logic [2:0] f3, input register_index_t rs1,
                                    input logic [11:0] imm);
        return {imm, rs1, f3, rd, opc};
    endfunction

    function automatic word_t asm_s(input logic [2:0] f3, input register_index_t rs1,
                                    input register_index_t rs2, input logic [11:0] imm);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
    endfunction

    function automatic word_t asm_b(input logic [2:0] f3, input register_index_t rs1,
                                    input register_index_t rs2, input word_t imm);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
    endfunction

    function automatic word_t asm_u(input logic [6:0] opc, input register_index_t rd,
                                    input word_t imm);
        return {imm[31:12], rd, opc};
    endfunction

    function automatic word_t asm_j(input register_index_t rd, input word_t imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
    endfunction

endpackage

// File: rtl/vermicel_regs.sv
// rtl/vermicel_regs.sv - 32-entry register file, two async read ports, one sync write port
module vermicel_regs
    import vermicel_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    input  logic        rd_we,
    input  logic [4:0]  rd_addr,
    input  logic [31:0] rd_wdata
);
    // Entry 0 is cleared by reset and never written, so it always reads zero.
    word_t x_reg [0:31];

    assign rs1_data = x_reg[rs1_addr];
    assign rs2_data = x_reg[rs2_addr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) x_reg[i] <= '0;
        end else if (rd_we && rd_addr != 5'd0) begin
            x_reg[rd_addr] <= rd_wdata;
        end
    end

endmodule

// File: rtl/vermicel_cpu.sv
// rtl/vermicel_cpu.sv - multi-cycle RV32I core with separate instruction and data ports
module vermicel_cpu
    import vermicel_pkg::*;
#(
    parameter logic [31:0] RESET_ADDRESS = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ibus_valid,
    output logic [31:0] ibus_address,
    input  logic [31:0] ibus_rdata,
    input  logic        ibus_ready,
    output logic        dbus_valid,
    output logic [31:0] dbus_address,
    output logic [3:0]  dbus_wstrobe,
    output logic [31:0] dbus_wdata,
    input  logic [31:0] dbus_rdata,
    input  logic        dbus_ready,
    input  logic        dbus_irq
);
    state_t          state_q, state_d;
    word_t           pc_q, pc_d, instr_q, instr_d, rdata_q, rdata_d;
    logic [6:0]      opcode, funct7;
    logic [2:0]      funct3;
    register_index_t rd, rs1, rs2;
    word_t           imm_i, imm_s, imm_b, imm_u, imm_j;
    word_t           rs1_val, rs2_val, alu_b, alu_out, mem_addr, next_pc, wb_val, lane, half;
    alu_fn_t         alu_fn;
    logic            taken, rd_we;
    wstrobe_t        strobe;
    logic            irq_unused;

    assign irq_unused = dbus_irq;

    assign opcode = instr_q[6:0];
    assign rd     = instr_q[11:7];
    assign funct3 = instr_q[14:12];
    assign rs1    = instr_q[19:15];
    assign rs2    = instr_q[24:20];
    assign funct7 = instr_q[31:25];
    assign imm_i  = {{20{instr_q[31]}}, instr_q[31:20]};
    assign imm_s  = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
    assign imm_b  = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
    assign imm_u  = {instr_q[31:12], 12'd0};
    assign imm_j  = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};

    vermicel_regs regs (
        .clk      (clk),
        .reset    (reset),
        .rs1_addr (rs1),
        .rs2_addr (rs2),
        .rs1_data (rs1_val),
        .rs2_data (rs2_val),
        .rd_we    (rd_we),
        .rd_addr  (rd),
        .rd_wdata (wb_val)
    );

    always_comb begin
        case (funct3)
            F3_BEQ:  taken = rs1_val == rs2_val;
            F3_BNE:  taken = rs1_val != rs2_val;
            F3_BLT:  taken = $signed(rs1_val) <  $signed(rs2_val);
            F3_BGE:  taken = $signed(rs1_val) >= $signed(rs2_val);
            F3_BLTU: taken = rs1_val <  rs2_val;
            F3_BGEU: taken = rs1_val >= rs2_val;
            default: taken = 1'b0;
        endcase
    end

    // Register operands stay stable until writeback, so everything below is
    // evaluated combinationally and holds across the whole instruction.
    always_comb begin
        case (funct3)
            F3_ADD:  alu_fn = (opcode == OPC_OP && funct7[5]) ? ALU_SUB : ALU_ADD;
            F3_SLL:  alu_fn = ALU_SLL;
            F3_SLT:  alu_fn = ALU_SLT;
            F3_SLTU: alu_fn = ALU_SLTU;
            F3_XOR:  alu_fn = ALU_XOR;
            F3_SR:   alu_fn = funct7[5] ? ALU_SRA : ALU_SRL;
            F3_OR:   alu_fn = ALU_OR;
            default: alu_fn = ALU_AND;
        endcase
        alu_b    = (opcode == OPC_OP) ? rs2_val : imm_i;
        alu_out  = alu(alu_fn, rs1_val, alu_b);
        mem_addr = rs1_val + ((opcode == OPC_STORE) ? imm_s : imm_i);

        case (opcode)
            OPC_JAL:    next_pc = pc_q + imm_j;
            OPC_JALR:   next_pc = (rs1_val + imm_i) & 32'hFFFF_FFFE;
            OPC_BRANCH: next_pc = taken ? pc_q + imm_b : pc_q + 32'd4;
            default:    next_pc = pc_q + 32'd4;
        endcase

        lane = rdata_q >> {mem_addr[1:0], 3'b000};
        half = mem_addr[1] ? {16'd0, rdata_q[31:16]} : {16'd0, rdata_q[15:0]};
        case (opcode)
            OPC_LUI:            wb_val = imm_u;
            OPC_AUIPC:          wb_val = pc_q + imm_u;
            OPC_JAL, OPC_JALR:  wb_val = pc_q + 32'd4;
            OPC_LOAD: begin
                case (funct3)
                    F3_B:    wb_val = {{24{lane[7]}}, lane[7:0]};
                    F3_H:    wb_val = {{16{half[15]}}, half[15:0]};
                    F3_BU:   wb_val = {24'd0, lane[7:0]};
                    F3_HU:   wb_val = half;
                    default: wb_val = rdata_q;
                endcase
            end
            default:            wb_val = alu_out;
        endcase

        case (funct3)
            F3_B: begin
                strobe     = 4'b0001 << mem_addr[1:0];
                dbus_wdata = {4{rs2_val[7:0]}};
            end
            F3_H: begin
                strobe     = mem_addr[1] ? 4'b1100 : 4'b0011;
                dbus_wdata = {2{rs2_val[15:0]}};
            end
            default: begin
                strobe     = 4'b1111;
                dbus_wdata = rs2_val;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        rdata_d = rdata_q;
        rd_we   = 1'b0;
        case (state_q)
            ST_FETCH: if (ibus_ready) begin
                instr_d = ibus_rdata;
                state_d = ST_DECODE;
            end
            ST_DECODE: state_d = ST_EXECUTE;
            ST_EXECUTE: begin
                case (opcode)
                    OPC_LOAD:  state_d = ST_LOAD;
                    OPC_STORE: state_d = ST_STORE;
                    OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_OP, OPC_OP_IMM:
                        state_d = ST_WRITEBACK;
                    default: begin
                        state_d = ST_FETCH;
                        pc_d    = next_pc;
                    end
                endcase
            end
            ST_LOAD: if (dbus_ready) begin
                rdata_d = dbus_rdata;
                state_d = ST_WRITEBACK;
            end
            ST_STORE: if (dbus_ready) begin
                state_d = ST_FETCH;
                pc_d    = next_pc;
            end
            ST_WRITEBACK: begin
                rd_we   = 1'b1;
                state_d = ST_FETCH;
                pc_d    = next_pc;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_ADDRESS;
            instr_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            rdata_q <= rdata_d;
        end
    end

    assign ibus_valid   = state_q == ST_FETCH;
    assign ibus_address = pc_q;
    assign dbus_valid   = state_q == ST_LOAD || state_q == ST_STORE;
    assign dbus_address = mem_addr;
    assign dbus_wstrobe = (state_q == ST_STORE) ? strobe : 4'b0000;

endmodule

// File: tb/tb_vermicel_cpu.sv
// tb/tb_vermicel_cpu.sv - scoreboard bench with an instruction-level reference model
module tb_vermicel_cpu;
    import vermicel_pkg::*;

    localparam int K_FETCH = 0, K_DATA = 1, K_REG = 2;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        bit          chk_wdata;
        int          idx;
        logic [31:0] val;
        int          lat;
    } item_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ibus_valid, dbus_valid;
    logic [31:0] ibus_address, dbus_address, dbus_wdata;
    logic [3:0]  dbus_wstrobe;
    logic [31:0] ibus_rdata = '0, dbus_rdata = '0;
    logic        ibus_ready = 1'b0, dbus_ready = 1'b0, dbus_irq = 1'b0;

    item_t       exp_q[$];
    int          checks = 0, errors = 0;
    logic [31:0] m_x [32];
    logic [31:0] m_pc = 32'h0;
    int          next_lat = -1;
    bit          mon_en = 1'b0;

    vermicel_cpu #(.RESET_ADDRESS(32'h0000_0000)) dut (
        .clk          (clk),
        .reset        (reset),
        .ibus_valid   (ibus_valid),
        .ibus_address (ibus_address),
        .ibus_rdata   (ibus_rdata),
        .ibus_ready   (ibus_ready),
        .dbus_valid   (dbus_valid),
        .dbus_address (dbus_address),
        .dbus_wstrobe (dbus_wstrobe),
        .dbus_wdata   (dbus_wdata),
        .dbus_rdata   (dbus_rdata),
        .dbus_ready   (dbus_ready),
        .dbus_irq     (dbus_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic abort_run(input string what);
        errors++;
        $display("FAIL timeout_%s: no request within 40 cycles, required one", what);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    function automatic logic [31:0] ref_alu(input logic [2:0] f3, input bit alt,
                                            input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0: return alt ? a - b : a + b;
            3'd1: return a << b[4:0];
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    // Architectural step: updates model state and queues the bus/register effects.
    task automatic exec(input logic [31:0] ins, input logic [31:0] rdata);
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [31:0] a, b, ii, is, ib, iu, ij, ea, v, npc, lane, half;
        bit          wr, taken;
        item_t       it;
        rd = ins[11:7]; f3 = ins[14:12]; rs1 = ins[19:15]; rs2 = ins[24:20];
        a  = m_x[rs1]; b = m_x[rs2];
        ii = {{20{ins[31]}}, ins[31:20]};
        is = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        ib = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        iu = {ins[31:12], 12'd0};
        ij = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        npc = m_pc + 4; wr = 0; v = 0; next_lat = 4;
        it = '{kind: K_DATA, addr: 0, strb: 0, wdata: 0, chk_wdata: 0, idx: 0, val: 0, lat: 3};
        case (ins[6:0])
            7'h37: begin v = iu; wr = 1; end
            7'h17: begin v = m_pc + iu; wr = 1; end
            7'h6f: begin v = m_pc + 4; wr = 1; npc = m_pc + ij; end
            7'h67: begin v = m_pc + 4; wr = 1; npc = (a + ii) & 32'hFFFF_FFFE; end
            7'h13: begin v = ref_alu(f3, f3 == 3'd5 && ins[30], a, ii); wr = 1; end
            7'h33: begin v = ref_alu(f3, ins[30], a, b); wr = 1; end
            7'h63: begin
                case (f3)
                    3'd0: taken = a == b;
                    3'd1: taken = a != b;
                    3'd4: taken = $signed(a) < $signed(b);
                    3'd5: taken = $signed(a) >= $signed(b);
                    3'd6: taken = a < b;
                    default: taken = a >= b;
                endcase
                if (taken) npc = m_pc + ib;
                next_lat = 3;
            end
            7'h03: begin
                ea = a + ii;
                it.addr = ea; it.strb = 4'b0000;
                exp_q.push_back(it);
                lane = rdata >> (8 * ea[1:0]);
                half = ea[1] ? rdata >> 16 : rdata;
                case (f3)
                    3'd0: v = 32'($signed(lane[7:0]));
                    3'd1: v = 32'($signed(half[15:0]));
                    3'd4: v = {24'd0, lane[7:0]};
                    3'd5: v = {16'd0, half[15:0]};
                    default: v = rdata;
                endcase
                wr = 1; next_lat = 2;
            end
            7'h23: begin
                ea = a + is;
                it.addr = ea; it.chk_wdata = 1;
                case (f3)
                    3'd0: begin it.strb = 4'b0001 << ea[1:0]; it.wdata = {4{b[7:0]}}; end
                    3'd1: begin it.strb = 4'b0011 << (2 * ea[1]); it.wdata = {2{b[15:0]}}; end
                    default: begin it.strb = 4'b1111; it.wdata = b; end
                endcase
                exp_q.push_back(it);
                next_lat = 1;
            end
            default: next_lat = 3;
        endcase
        if (wr) begin
            if (rd != 0) m_x[rd] = v;
            it = '{kind: K_REG, addr: 0, strb: 0, wdata: 0, chk_wdata: 0, idx: int'(rd), val: m_x[rd], lat: 0};
            exp_q.push_back(it);
        end
        m_pc = npc;
    endtask

    task automatic wait_req(input bit is_d, output bit ok);
        int n = 0;
        while (!(is_d ? dbus_valid : ibus_valid) && n < 40) begin
            @(negedge clk);
            n++;
        end
        ok = n < 40;
    endtask

    task automatic push_fetch();
        item_t it;
        it = '{kind: K_FETCH, addr: m_pc, strb: 0, wdata: 0, chk_wdata: 0, idx: 0, val: 0, lat: next_lat};
        exp_q.push_back(it);
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] rdata, input int wi, input int wd);
        bit ok;
        wait_req(1'b0, ok);
        if (!ok) abort_run("fetch");
        push_fetch();
        exec(ins, rdata);
        repeat (wi) @(negedge clk);
        ibus_rdata = ins; ibus_ready = 1'b1;
        @(negedge clk);
        ibus_ready = 1'b0; ibus_rdata = $urandom;
        if (ins[6:0] == OPC_LOAD || ins[6:0] == OPC_STORE) begin
            wait_req(1'b1, ok);
            if (!ok) abort_run("data");
            repeat (wd) @(negedge clk);
            dbus_rdata = rdata; dbus_ready = 1'b1;
            @(negedge clk);
            dbus_ready = 1'b0; dbus_rdata = $urandom;
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rd, rs1, rs2, sh;
        logic [2:0]  f3;
        logic [11:0] imm;
        logic [31:0] r;
        rd  = 5'($urandom_range(0, 7));
        rs1 = 5'($urandom_range(0, 7));
        rs2 = 5'($urandom_range(0, 7));
        sh  = 5'($urandom);
        f3  = 3'($urandom);
        imm = 12'($urandom);
        case ($urandom_range(0, 11))
            0: r = asm_u(OPC_LUI, rd, $urandom);
            1: r = asm_u(OPC_AUIPC, rd, $urandom);
            2: r = asm_j(rd, $urandom & 32'h001F_FFFE);
            3: r = asm_i(OPC_JALR, rd, 3'd0, rs1, imm);
            4, 5: begin
                if (f3 == 3'd1) imm = {7'h00, sh};
                else if (f3 == 3'd5) imm = {($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00, sh};
                r = asm_i(OPC_OP_IMM, rd, f3, rs1, imm);
            end
            6, 7: r = asm_r(((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) != 0) ? 7'h20 : 7'h00,
                            f3, rd, rs1, rs2);
            8: begin
                f3 = 3'($urandom_range(0, 5));
                if (f3 > 3'd1) f3 = f3 + 3'd2;
                r = asm_b(f3, rs1, rs2, $urandom & 32'h0000_1FFE);
            end
            9: begin
                f3 = 3'($urandom_range(0, 4));
                if (f3 > 3'd2) f3 = f3 + 3'd1;
                r = asm_i(OPC_LOAD, rd, f3, rs1, imm);
            end
            10: r = asm_s(3'($urandom_range(0, 2)), rs1, rs2, imm);
            default: begin
                case ($urandom_range(0, 2))
                    0: r = asm_i(OPC_FENCE, 5'd0, 3'd0, 5'd0, 12'h0ff);
                    1: r = 32'h0000_0073;
                    default: r = 32'h0010_0073;
                endcase
            end
        endcase
        return r;
    endfunction

    // Monitor: compares every bus request against the head of the scoreboard.
    initial begin
        int    gap;
        bit    ipend, dpend;
        item_t r;
        gap = 0; ipend = 0; dpend = 0;
        forever begin
            @(negedge clk);
            #2;
            if (!mon_en) begin
                gap = 0; ipend = 0; dpend = 0;
            end else begin
                gap++;
                checks++;
                if (ibus_valid && dbus_valid) begin
                    errors++;
                    $display("FAIL both_valid: ibus_valid=1 dbus_valid=1, required at most one");
                end
                if (ibus_valid) begin
                    while (exp_q.size() > 0 && exp_q[0].kind == K_REG) begin
                        r = exp_q.pop_front();
                        check($sformatf("x%0d", r.idx), dut.regs.x_reg[r.idx], r.val);
                    end
                    if (exp_q.size() == 0 || exp_q[0].kind != K_FETCH) begin
                        check("unexpected_fetch", ibus_address, 32'hxxxx_xxxx);
                    end else begin
                        check("ibus_address", ibus_address, exp_q[0].addr);
                        if (!ipend && exp_q[0].lat >= 0)
                            check("fetch_latency", 32'(gap), 32'(exp_q[0].lat));
                        if (ibus_ready) begin
                            void'(exp_q.pop_front());
                            gap = 0; ipend = 0;
                        end else ipend = 1;
                    end
                end
                if (dbus_valid) begin
                    if (exp_q.size() == 0 || exp_q[0].kind != K_DATA) begin
                        check("unexpected_data", dbus_address, 32'hxxxx_xxxx);
                    end else begin
                        check("dbus_address", dbus_address, exp_q[0].addr);
                        check("dbus_wstrobe", {28'd0, dbus_wstrobe}, {28'd0, exp_q[0].strb});
                        if (exp_q[0].chk_wdata) check("dbus_wdata", dbus_wdata, exp_q[0].wdata);
                        if (!dpend) check("data_latency", 32'(gap), 32'(exp_q[0].lat));
                        if (dbus_ready) begin
                            void'(exp_q.pop_front());
                            gap = 0; dpend = 0;
                        end else dpend = 1;
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: simulation time exceeded, required completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        bit ok;
        for (int i = 0; i < 32; i++) m_x[i] = '0;
        #2;
        check("reset_ibus_valid", {31'd0, ibus_valid}, 32'd1);
        check("reset_ibus_address", ibus_address, 32'h0);
        check("reset_dbus_valid", {31'd0, dbus_valid}, 32'd0);
        check("reset_dbus_wstrobe", {28'd0, dbus_wstrobe}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        mon_en = 1'b1;

        issue(asm_u(OPC_LUI, 5'd4, 32'h0000_A000), $urandom, 1, 0);
        issue(asm_i(OPC_OP_IMM, 5'd5, 3'd0, 5'd0, 12'h096), $urandom, 0, 0);
        issue(asm_s(F3_W, 5'd4, 5'd5, 12'h100), $urandom, 0, 1);
        issue(asm_s(F3_H, 5'd4, 5'd5, 12'h100), $urandom, 0, 0);
        issue(asm_s(F3_H, 5'd4, 5'd5, 12'h102), $urandom, 0, 0);
        for (int k = 0; k < 4; k++) issue(asm_s(F3_B, 5'd4, 5'd5, 12'(12'h100 + k)), $urandom, 0, 0);
        issue(asm_i(OPC_LOAD, 5'd6, F3_W, 5'd4, 12'h100), 32'h8C15_F3E4, 0, 1);
        issue(asm_i(OPC_LOAD, 5'd7, F3_H, 5'd4, 12'h100), 32'h8C15_F3E4, 0, 0);
        issue(asm_i(OPC_LOAD, 5'd7, F3_H, 5'd4, 12'h102), 32'h8C15_F3E4, 0, 0);
        issue(asm_i(OPC_LOAD, 5'd7, F3_HU, 5'd4, 12'h100), 32'h8C15_F3E4, 0, 0);
        issue(asm_i(OPC_LOAD, 5'd7, F3_HU, 5'd4, 12'h102), 32'h8C15_F3E4, 0, 0);
        for (int k = 0; k < 4; k++)
            issue(asm_i(OPC_LOAD, 5'd7, F3_B, 5'd4, 12'(12'h100 + k)), 32'h8C15_F3E4, 0, 0);
        issue(asm_b(F3_BEQ, 5'd5, 5'd5, 32'h10), $urandom, 0, 0);
        issue(asm_b(F3_BEQ, 5'd5, 5'd4, 32'h10), $urandom, 0, 0);
        issue(asm_j(5'd1, 32'h8), $urandom, 0, 0);
        issue(asm_i(OPC_JALR, 5'd2, 3'd0, 5'd1, 12'h021), $urandom, 0, 0);
        issue(asm_u(OPC_LUI, 5'd8, 32'h8000_0000), $urandom, 0, 0);
        issue(asm_i(OPC_OP_IMM, 5'd8, 3'd0, 5'd8, 12'hFFF), $urandom, 0, 0);
        issue(asm_i(OPC_OP_IMM, 5'd9, 3'd0, 5'd0, 12'h001), $urandom, 0, 0);
        issue(asm_r(7'h00, 3'd0, 5'd10, 5'd8, 5'd9), $urandom, 0, 0);
        issue(asm_i(OPC_OP_IMM, 5'd0, 3'd0, 5'd9, 12'h055), $urandom, 0, 0);

        for (int n = 0; n < 400; n++)
            issue(rand_instr(), $urandom, $urandom_range(0, 2), $urandom_range(0, 2));

        wait_req(1'b0, ok);
        if (!ok) abort_run("final_fetch");
        push_fetch();
        repeat (2) @(negedge clk);
        mon_en = 1'b0;
        check("queue_drained", 32'(exp_q.size()), 32'd1);

        // Abort an instruction in EXECUTE with reset and confirm the core restarts cleanly.
        ibus_rdata = asm_i(OPC_LOAD, 5'd3, F3_W, 5'd0, 12'h040); ibus_ready = 1'b1;
        @(negedge clk);
        ibus_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_ibus_valid", {31'd0, ibus_valid}, 32'd1);
        check("abort_ibus_address", ibus_address, 32'h0);
        check("abort_dbus_valid", {31'd0, dbus_valid}, 32'd0);
        check("abort_dbus_wstrobe", {28'd0, dbus_wstrobe}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("restart_ibus_valid", {31'd0, ibus_valid}, 32'd1);
        check("restart_dbus_valid", {31'd0, dbus_valid}, 32'd0);
        check("restart_x3", dut.regs.x_reg[3], 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
